// File: rtl/maze_gen_ctrl.sv
// Sequencer for the 16x16 maze carver: start/finish handshake with timeout,
// bitmap snapshot with forced entry/exit cells, and a two-port round-robin cell reader.
module maze_gen_ctrl #(
  parameter int unsigned START_HOLD = 4,
  parameter int unsigned TIMEOUT    = 1048575,
  parameter int unsigned ENTRY_IDX  = 17,
  parameter int unsigned EXIT_IDX   = 238
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_maze,
  output logic         carve_start,
  input  logic         carve_finish,
  input  logic [255:0] carve_maze,
  output logic         busy,
  output logic         maze_valid,
  output logic         timeout_err,
  input  logic         rd_req_a,
  input  logic         rd_req_b,
  input  logic [3:0]   rd_x_a,
  input  logic [3:0]   rd_y_a,
  input  logic [3:0]   rd_x_b,
  input  logic [3:0]   rd_y_b,
  output logic         rd_gnt_a,
  output logic         rd_gnt_b,
  output logic         rd_data_a,
  output logic         rd_data_b
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE, S_CAPTURE, S_READY, S_ERROR
  } state_e;

  localparam logic [3:0]  HOLD_LAST = 4'(START_HOLD - 1);
  localparam logic [19:0] TO_LAST   = 20'(TIMEOUT - 1);
  localparam logic [7:0]  ENTRY_BIT = 8'(ENTRY_IDX);
  localparam logic [7:0]  EXIT_BIT  = 8'(EXIT_IDX);

  state_e         state_q, state_d;
  logic [3:0]     hold_q, hold_d;
  logic [19:0]    to_q, to_d;
  logic           err_q, err_d;
  logic [255:0]   snap_q, snap_d;
  logic           prio_b_q, prio_b_d;  // 1: B wins the next contested cycle
  logic           data_a_q, data_a_d;
  logic           data_b_q, data_b_d;
  logic           gnt_a, gnt_b;
  logic [7:0]     idx_a, idx_b;

  assign idx_a = {rd_y_a, rd_x_a};
  assign idx_b = {rd_y_b, rd_x_b};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      to_q     <= '0;
      err_q    <= 1'b0;
      // NOTE: the snapshot is a plain register bank, so resetting it is cheap
      // and keeps reads after reset deterministic.
      snap_q   <= '0;
      prio_b_q <= 1'b0;
      data_a_q <= 1'b0;
      data_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      to_q     <= to_d;
      err_q    <= err_d;
      snap_q   <= snap_d;
      prio_b_q <= prio_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    to_d    = to_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_READY, S_ERROR: begin
        if (new_maze) begin
          state_d = S_START;
          err_d   = 1'b0;
        end
      end
      S_START: begin
        to_d = '0;
        if (!carve_finish) begin
          state_d = S_WAIT_ACK;
          hold_d  = '0;
        end
      end
      S_WAIT_ACK: begin
        to_d   = to_q + 20'd1;
        hold_d = carve_finish ? 4'd0 : hold_q + 4'd1;
        if (!carve_finish && hold_q == HOLD_LAST) begin
          state_d = S_WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        to_d = to_q + 20'd1;
        if (carve_finish) begin
          state_d = S_CAPTURE;
        end else if (to_q == TO_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      S_CAPTURE: state_d = S_READY;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    carve_start = (state_q == S_START) || (state_q == S_WAIT_ACK);
    busy        = (state_q == S_START) || (state_q == S_WAIT_ACK) ||
                  (state_q == S_WAIT_DONE) || (state_q == S_CAPTURE);
    maze_valid  = (state_q == S_READY);
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    // A restart request pre-empts any read in the same cycle.
    if (state_q == S_READY && !new_maze) begin
      if (rd_req_a && (!rd_req_b || !prio_b_q)) gnt_a = 1'b1;
      else if (rd_req_b)                         gnt_b = 1'b1;
    end
  end

  always_comb begin
    snap_d   = snap_q;
    prio_b_d = prio_b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (state_q == S_CAPTURE) begin
      snap_d            = carve_maze;
      snap_d[ENTRY_BIT] = 1'b1;
      snap_d[EXIT_BIT]  = 1'b1;
    end
    if (gnt_a) begin
      data_a_d = snap_q[idx_a];
      prio_b_d = 1'b1;
    end
    if (gnt_b) begin
      data_b_d = snap_q[idx_b];
      prio_b_d = 1'b0;
    end
  end

  assign timeout_err = err_q;
  assign rd_gnt_a    = gnt_a;
  assign rd_gnt_b    = gnt_b;
  assign rd_data_a   = data_a_q;
  assign rd_data_b   = data_b_q;

endmodule
